// File: rtl/pipe_pkg.sv
// Shared widths, operand-source encoding and the ID->EX stage record.
package pipe_pkg;
  localparam int XLEN   = 32;
  localparam int CTRL_W = 16;

  typedef enum logic [2:0] {FWD_ZERO, FWD_MEM, FWD_WB, FWD_CAP, FWD_RF} fwd_sel_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rd;
    logic              rd_we;
    logic              is_load;
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
  } id_ex_t;
endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode-side inputs and EX-side outputs of the ID->EX operand stage.
interface id_ex_operand_stage_if;
  import pipe_pkg::*;

  logic              id_valid;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic              id_rd_we;
  logic              id_is_load;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_imm;
  logic [CTRL_W-1:0] id_ctrl;

  logic              load_use_stall;
  logic              ex_valid;
  logic [4:0]        ex_rd;
  logic              ex_rd_we;
  logic              ex_is_load;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [XLEN-1:0]   ex_op1;
  logic [XLEN-1:0]   ex_op2;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_rd_we, id_is_load, id_pc, id_imm, id_ctrl,
    input  load_use_stall, ex_valid, ex_rd, ex_rd_we, ex_is_load, ex_pc, ex_imm, ex_ctrl,
           ex_op1, ex_op2
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_rd_we, id_is_load, id_pc, id_imm, id_ctrl,
    output load_use_stall, ex_valid, ex_rd, ex_rd_we, ex_is_load, ex_pc, ex_imm, ex_ctrl,
           ex_op1, ex_op2
  );
endinterface

// File: rtl/operand_bypass.sv
// One source operand: forwarding select, same-edge write capture and freeze hold.
module operand_bypass
  import pipe_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      ex_rs,
  input  logic [XLEN-1:0] rf_data,
  input  logic [4:0]      mem_rd,
  input  logic            mem_we,
  input  logic [XLEN-1:0] mem_data,
  input  logic [4:0]      wb_rd,
  input  logic            wb_we,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] op
);
  fwd_sel_e        sel;
  logic [XLEN-1:0] resolved;
  logic            cap_hit;
  logic [XLEN-1:0] cap_data;
  logic            hold_vld;
  logic [XLEN-1:0] hold_data;

  always_comb begin
    if (ex_rs == '0)                        sel = FWD_ZERO;
    else if (mem_we && (mem_rd == ex_rs))   sel = FWD_MEM;
    else if (wb_we && (wb_rd == ex_rs))     sel = FWD_WB;
    else if (cap_hit)                       sel = FWD_CAP;
    else                                    sel = FWD_RF;
  end

  always_comb begin
    resolved = '0;
    case (sel)
      FWD_ZERO: resolved = '0;
      FWD_MEM:  resolved = mem_data;
      FWD_WB:   resolved = wb_data;
      FWD_CAP:  resolved = cap_data;
      default:  resolved = rf_data;
    endcase
  end

  // RF reads before it writes, so a WB write landing on the latch edge is kept here.
  // During freeze the RF port follows decode, not EX, so the first resolved value is pinned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_hit   <= 1'b0;
      cap_data  <= '0;
      hold_vld  <= 1'b0;
      hold_data <= '0;
    end else if (freeze) begin
      if (!hold_vld) begin
        hold_data <= resolved;
        hold_vld  <= 1'b1;
      end
    end else begin
      hold_vld <= 1'b0;
      cap_hit  <= wb_we && (wb_rd != '0) && (wb_rd == id_rs);
      cap_data <= wb_data;
    end
  end

  assign op = hold_vld ? hold_data : resolved;
endmodule

// File: rtl/id_ex_operand_stage.sv
// ID->EX stage register with load-use bubble insertion, freeze/flush and operand resolution.
module id_ex_operand_stage
  import pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  id_ex_operand_stage_if.slave  bus,
  input  logic [XLEN-1:0]       rf_rs1_data,
  input  logic [XLEN-1:0]       rf_rs2_data,
  input  logic [4:0]            mem_rd,
  input  logic                  mem_we,
  input  logic [XLEN-1:0]       mem_data,
  input  logic [4:0]            wb_rd,
  input  logic                  wb_we,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  freeze,
  input  logic                  flush
);
  id_ex_t ex_q;
  id_ex_t id_in;
  logic   ex_valid_q;
  logic   stall;

  assign id_in = '{pc: bus.id_pc, imm: bus.id_imm, rd: bus.id_rd, rd_we: bus.id_rd_we,
                   is_load: bus.id_is_load, ctrl: bus.id_ctrl, rs1: bus.id_rs1, rs2: bus.id_rs2};

  assign stall = bus.id_valid && ex_valid_q && ex_q.is_load && (ex_q.rd != '0) &&
                 ((ex_q.rd == bus.id_rs1) || (ex_q.rd == bus.id_rs2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else if (!freeze) begin
      ex_q <= id_in;
      if (flush || stall) begin
        ex_valid_q <= 1'b0;
        ex_q.rd_we <= 1'b0;
      end else begin
        ex_valid_q <= bus.id_valid;
      end
    end
  end

  operand_bypass u_rs1 (
    .clk(clk), .rst(rst), .freeze(freeze), .id_rs(bus.id_rs1), .ex_rs(ex_q.rs1),
    .rf_data(rf_rs1_data), .mem_rd(mem_rd), .mem_we(mem_we), .mem_data(mem_data),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data), .op(bus.ex_op1)
  );

  operand_bypass u_rs2 (
    .clk(clk), .rst(rst), .freeze(freeze), .id_rs(bus.id_rs2), .ex_rs(ex_q.rs2),
    .rf_data(rf_rs2_data), .mem_rd(mem_rd), .mem_we(mem_we), .mem_data(mem_data),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data), .op(bus.ex_op2)
  );

  assign bus.load_use_stall = stall;
  assign bus.ex_valid       = ex_valid_q;
  assign bus.ex_rd          = ex_q.rd;
  assign bus.ex_rd_we       = ex_q.rd_we;
  assign bus.ex_is_load     = ex_q.is_load;
  assign bus.ex_pc          = ex_q.pc;
  assign bus.ex_imm         = ex_q.imm;
  assign bus.ex_ctrl        = ex_q.ctrl;
endmodule
